cpu7_mem_arb: RTL and testbench
===============================

// Module: cpu7_mem_arb
// PURPOSE
//  Two-port to one-port memory arbiter for the no-cache core: shares a single SRAM-like memory port
//  between the IFU fetch port (inst_*) and the EXU load/store port (data_*). Sits between the core
//  top and the memory/bridge. One transaction outstanding at a time; responses are routed back to the granted port.
// PARAMETERS
//  ADDR_W  32  address width, all ports
//  DATA_W  32  data width, all ports; wstrb width is DATA_W/8
// PORTS
//  clk            in   1        core clock; all logic on rising edge
//  resetn         in   1        asynchronous, active-low reset
//  inst_req       in   1        fetch request; held until inst_addr_ok
//  inst_addr      in   ADDR_W   fetch address
//  inst_cancel    in   1        drop pending/in-flight fetch
//  inst_addr_ok   out  1        fetch address accepted
//  inst_rdata     out  DATA_W   fetch data, valid with inst_valid
//  inst_valid     out  1        fetch data return
//  data_req       in   1        load/store request; held until data_addr_ok
//  data_wr        in   1        1=store 0=load
//  data_wstrb     in   DATA_W/8 store byte enables
//  data_addr      in   ADDR_W   load/store address
//  data_wdata     in   DATA_W   store data
//  data_cancel    in   1        drop pending/in-flight load
//  data_addr_ok   out  1        load/store address accepted
//  data_rdata     out  DATA_W   load data, valid with data_data_ok
//  data_data_ok   out  1        load data return / store completion
//  mem_req        out  1        memory request
//  mem_wr/mem_wstrb/mem_addr/mem_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  muxed request fields
//  mem_addr_ok    in   1        memory accepted request
//  mem_data_ok    in   1        memory response
//  mem_rdata      in   DATA_W   memory read data
// BEHAVIOUR
//  - Reset: state=IDLE, grant=NONE, drop=0, last_grant=INST; every output 0 while resetn=0. Reset
//    mid-transaction abandons it; a later mem_data_ok for it is ignored (arrives in IDLE).
//  - FSM IDLE->ADDR->DATA->IDLE.
//    IDLE: eligible = req & ~cancel per port. If any eligible, register grant, go ADDR. mem_req=0.
//    ADDR: mem_req=1, mem_* = granted port fields, held stable. On mem_addr_ok: granted *_addr_ok=1
//      same cycle (combinational pass), go DATA. mem_wr/mem_wstrb/mem_wdata forced 0 for INST grant.
//    DATA: on mem_data_ok: if drop=0, granted inst_valid / data_data_ok =1 same cycle with
//      *_rdata=mem_rdata; go IDLE, clear drop. Ungranted port outputs stay 0.
//  - Latency: source req -> mem_req 1 cycle; mem_data_ok -> source valid 0 cycles; min 3 cycles/txn.
//  - Priority (default): DATA over INST on simultaneous eligible requests.
//  - Cancel: granted port's cancel in ADDR or DATA sets drop=1 (request still completes on mem side,
//    response suppressed). data_cancel ignored for stores (store always completes and reports data_data_ok).
//    Cancel in IDLE only masks eligibility that cycle.
//  - mem_addr_ok outside ADDR and mem_data_ok outside DATA are ignored. mem_data_ok same cycle as new
//    req: return response, go IDLE, arbitrate next cycle.
//  - *_rdata are 0 whenever the matching valid is 0.
// CONFIGURATION
//  CPU7_MEM_ARB_RR_EN defined: round-robin; on simultaneous eligible requests grant the port not equal
//    to last_grant; last_grant updated on every grant. Undefined: fixed DATA>INST, last_grant unused.
// STRUCTURE
//  - Shared header cpu7_arb_defs.vh (package role): FSM state encodings ARB_IDLE/ARB_ADDR/ARB_DATA,
//    grant encodings GNT_NONE/GNT_INST/GNT_DATA.
//  - One sub-module cpu7_arb_pick: 2-way combinational picker (eligible, last_grant -> grant), holds
//    the RR/fixed selection under the macro. FSM, drop flag and muxes stay in cpu7_mem_arb.
// TESTING
//  1 inst_req only, addr 0x1c000000; mem_addr_ok next cycle, mem_data_ok +2 with 0x02800000 ->
//    mem_req rises 1 cycle after req, inst_addr_ok with mem_addr_ok, inst_valid 1 cycle, inst_rdata=0x02800000.
//  2 inst_req and data_req (load 0x1c000100) same cycle -> data granted first; inst granted after data
//    completes (fixed); with CPU7_MEM_ARB_RR_EN and last_grant=DATA -> inst granted first.
//  3 store data_wstrb=4'b0011 data_wdata=0xdeadbeef -> mem_wr=1, mem_wstrb=0011, data_data_ok on mem_data_ok;
//    data_cancel in DATA still yields data_data_ok.
//  4 inst_cancel pulsed in DATA -> mem_data_ok consumed, inst_valid stays 0, next fetch arbitrated normally.
//  5 resetn low while in DATA, release, then mem_data_ok -> no inst_valid/data_data_ok, all outputs 0, state IDLE.
//  6 mem_addr_ok stalled 5 cycles -> mem_req and mem_addr stable throughout, no *_addr_ok until accepted.

Source files
------------

// File: rtl/cpu7_mem_arb_pkg.sv
// Shared encodings for the cpu7 two-port memory arbiter: FSM states and grant owners.
package cpu7_mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_INST = 2'd1,
        GNT_DATA = 2'd2
    } arb_gnt_t;

endpackage

// File: rtl/cpu7_mem_arb_pick.sv
// 2-way combinational picker for the memory arbiter: eligible requests -> grant owner.
// CPU7_MEM_ARB_RR_EN selects round-robin against last_grant; otherwise DATA beats INST.
module cpu7_arb_pick
    import cpu7_mem_arb_pkg::*;
(
    input  logic [1:0] eligible,    // [1]=data port, [0]=inst port
`ifdef CPU7_MEM_ARB_RR_EN
    input  logic [1:0] last_grant,
`endif
    output logic [1:0] grant
);

    always_comb begin
        grant = GNT_NONE;
        case (eligible)
            2'b01: grant = GNT_INST;
            2'b10: grant = GNT_DATA;
            2'b11: begin
`ifdef CPU7_MEM_ARB_RR_EN
                // Contested: hand the port to whoever did not win last time.
                grant = (last_grant == GNT_DATA) ? GNT_INST : GNT_DATA;
`else
                grant = GNT_DATA;
`endif
            end
            default: grant = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/cpu7_mem_arb.sv
// Shares one SRAM-like memory port between the fetch (inst_*) and load/store (data_*) ports,
// one transaction at a time. Define CPU7_MEM_ARB_RR_EN for round-robin arbitration.
module cpu7_mem_arb
    import cpu7_mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic                inst_cancel,
    output logic                inst_addr_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_valid,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    input  logic                data_cancel,
    output logic                data_addr_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_data_ok,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_t state_reg, state_next;
    arb_gnt_t   grant_reg, grant_next;
    logic       drop_reg, drop_next;
    logic       store_reg, store_next;
`ifdef CPU7_MEM_ARB_RR_EN
    arb_gnt_t   last_grant_reg, last_grant_next;
`endif

    logic [1:0] eligible;
    logic [1:0] pick_grant;
    logic       is_inst;
    logic       is_data;
    logic       cancel_now;
    logic       deliver;

    assign eligible = {data_req & ~data_cancel, inst_req & ~inst_cancel};
    assign is_inst  = (grant_reg == GNT_INST);
    assign is_data  = (grant_reg == GNT_DATA);

    // Stores always complete and report, so data_cancel only matters for loads.
    assign cancel_now = (is_inst & inst_cancel) | (is_data & data_cancel & ~store_reg);
    assign deliver    = ~(drop_reg | cancel_now);

    cpu7_arb_pick u_pick (
        .eligible   (eligible),
`ifdef CPU7_MEM_ARB_RR_EN
        .last_grant (last_grant_reg),
`endif
        .grant      (pick_grant)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= ARB_IDLE;
            grant_reg      <= GNT_NONE;
            drop_reg       <= 1'b0;
            store_reg      <= 1'b0;
`ifdef CPU7_MEM_ARB_RR_EN
            last_grant_reg <= GNT_INST;
`endif
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            drop_reg       <= drop_next;
            store_reg      <= store_next;
`ifdef CPU7_MEM_ARB_RR_EN
            last_grant_reg <= last_grant_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        drop_next       = drop_reg;
        store_next      = store_reg;
`ifdef CPU7_MEM_ARB_RR_EN
        last_grant_next = last_grant_reg;
`endif
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_wstrb    = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        inst_addr_ok = 1'b0;
        inst_valid   = 1'b0;
        inst_rdata   = '0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = '0;

        case (state_reg)
            ARB_IDLE: begin
                if (|eligible) begin
                    grant_next = arb_gnt_t'(pick_grant);
                    store_next = (pick_grant == GNT_DATA) & data_wr;
                    drop_next  = 1'b0;
                    state_next = ARB_ADDR;
`ifdef CPU7_MEM_ARB_RR_EN
                    last_grant_next = arb_gnt_t'(pick_grant);
`endif
                end
            end

            ARB_ADDR: begin
                mem_req = 1'b1;
                if (is_inst) begin
                    mem_addr = inst_addr;
                end else begin
                    mem_addr  = data_addr;
                    mem_wr    = data_wr;
                    mem_wstrb = data_wstrb;
                    mem_wdata = data_wdata;
                end
                if (cancel_now) begin
                    drop_next = 1'b1;
                end
                if (mem_addr_ok) begin
                    inst_addr_ok = is_inst;
                    data_addr_ok = is_data;
                    state_next   = ARB_DATA;
                end
            end

            ARB_DATA: begin
                if (cancel_now) begin
                    drop_next = 1'b1;
                end
                if (mem_data_ok) begin
                    // A cancel arriving with the response itself still suppresses it.
                    if (deliver) begin
                        inst_valid   = is_inst;
                        inst_rdata   = is_inst ? mem_rdata : '0;
                        data_data_ok = is_data;
                        data_rdata   = is_data ? mem_rdata : '0;
                    end
                    state_next = ARB_IDLE;
                    grant_next = GNT_NONE;
                    drop_next  = 1'b0;
                end
            end

            default: begin
                state_next = ARB_IDLE;
                grant_next = GNT_NONE;
                drop_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu7_mem_arb.sv
// Self-checking bench for cpu7_mem_arb: directed scenarios plus randomized transactions
// checked against a transaction-level model of grant order and response routing.
module tb_cpu7_mem_arb;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_cancel;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_valid;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_cancel;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;
    int lg    = 1;          // model of last grant: 1 = inst, 2 = data

    logic [137:0] all_outs;
    assign all_outs = {mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, inst_addr_ok,
                       inst_valid, inst_rdata, data_addr_ok, data_data_ok, data_rdata};

    always #5 clk = ~clk;

    cpu7_mem_arb #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
        .inst_addr_ok(inst_addr_ok), .inst_rdata(inst_rdata), .inst_valid(inst_valid),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_cancel(data_cancel), .data_addr_ok(data_addr_ok),
        .data_rdata(data_rdata), .data_data_ok(data_data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    task automatic clear_inputs();
        inst_req = 0; inst_addr = 0; inst_cancel = 0;
        data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0; data_cancel = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    // One or two requests issued together; the memory side is played with the given stall
    // and data wait. cancel_first pulses the first granted port's cancel during its data phase.
    task automatic do_txn(input int kind, input logic [31:0] ia, input logic [31:0] da,
                          input logic [31:0] dw, input logic [3:0] ws, input int stall,
                          input int dwait, input bit cancel_first);
        int order [2];
        int n, g, c;
        bit found, do_inst, do_data, is_st, exp_v;
        logic [31:0] ea, ewd, rd;
        logic        ewr;
        logic [3:0]  ews;
        logic [65:0] ev;
        do_inst = (kind == 0) || (kind == 3) || (kind == 4);
        do_data = (kind != 0);
        is_st   = (kind == 2) || (kind == 4);
        if (do_inst) begin inst_req = 1; inst_addr = ia; end
        if (do_data) begin
            data_req = 1; data_addr = da; data_wr = is_st; data_wstrb = ws; data_wdata = dw;
        end
        if (do_inst && do_data) begin
`ifdef CPU7_MEM_ARB_RR_EN
            order[0] = (lg == 1) ? 2 : 1;
`else
            order[0] = 2;
`endif
            order[1] = 3 - order[0];
            n = 2;
        end else begin
            order[0] = do_inst ? 1 : 2;
            order[1] = 0;
            n = 1;
        end
        for (int k = 0; k < n; k++) begin
            g = order[k];
            found = 0; c = 0;
            while (!found && c < 6) begin
                @(negedge clk); #1;
                if (mem_req) found = 1; else c++;
            end
            tests++;
            if (!found || c != 0) begin
                fails++;
                $display("FAIL req_latency port=%0d: waited %0d extra cycles, required 0", g, c);
            end
            if (!found) begin
                clear_inputs();
                @(negedge clk);
                return;
            end
            lg = g;
            if (g == 1) begin ea = ia; ewr = 0; ews = 0; ewd = 0; end
            else begin ea = da; ewr = is_st; ews = ws; ewd = dw; end
            tests++;
            if ({mem_addr, mem_wr, mem_wstrb, mem_wdata} !== {ea, ewr, ews, ewd}) begin
                fails++;
                $display("FAIL mem_fields port=%0d: got addr=%h wr=%b strb=%b wdata=%h, required addr=%h wr=%b strb=%b wdata=%h",
                         g, mem_addr, mem_wr, mem_wstrb, mem_wdata, ea, ewr, ews, ewd);
            end
            for (int s = 0; s < stall; s++) begin
                tests++;
                if ({mem_req, mem_addr, inst_addr_ok, data_addr_ok} !== {1'b1, ea, 2'b00}) begin
                    fails++;
                    $display("FAIL addr_stall cycle %0d: got req=%b addr=%h aok=%b%b, required req=1 addr=%h aok=00",
                             s, mem_req, mem_addr, inst_addr_ok, data_addr_ok, ea);
                end
                @(negedge clk); #1;
            end
            mem_addr_ok = 1; #1;
            tests++;
            if ({inst_addr_ok, data_addr_ok} !== {g == 1, g == 2}) begin
                fails++;
                $display("FAIL addr_ok port=%0d: got inst=%b data=%b", g, inst_addr_ok, data_addr_ok);
            end
            @(negedge clk);
            mem_addr_ok = 0;
            if (g == 1) inst_req = 0; else data_req = 0;
            #1;
            tests++;
            if (mem_req !== 1'b0) begin
                fails++;
                $display("FAIL data_phase_req: got mem_req=%b, required 0", mem_req);
            end
            if (cancel_first && k == 0) begin
                if (g == 1) inst_cancel = 1; else data_cancel = 1;
                @(negedge clk);
                inst_cancel = 0; data_cancel = 0;
            end
            for (int w = 0; w < dwait; w++) begin
                mem_rdata = $urandom; #1;
                tests++;
                if ({inst_valid, inst_rdata, data_data_ok, data_rdata} !== 66'd0) begin
                    fails++;
                    $display("FAIL early_resp: got iv=%b ird=%h dok=%b drd=%h, required all 0",
                             inst_valid, inst_rdata, data_data_ok, data_rdata);
                end
                @(negedge clk);
            end
            rd = $urandom;
            mem_rdata = rd; mem_data_ok = 1; #1;
            exp_v = !(cancel_first && k == 0) || (g == 2 && is_st);
            ev = {(g == 1) && exp_v, ((g == 1) && exp_v) ? rd : 32'd0,
                  (g == 2) && exp_v, ((g == 2) && exp_v) ? rd : 32'd0};
            tests++;
            if ({inst_valid, inst_rdata, data_data_ok, data_rdata} !== ev) begin
                fails++;
                $display("FAIL response port=%0d: got iv=%b ird=%h dok=%b drd=%h, required iv=%b ird=%h dok=%b drd=%h",
                         g, inst_valid, inst_rdata, data_data_ok, data_rdata,
                         ev[65], ev[64:33], ev[32], ev[31:0]);
            end
            @(negedge clk);
            mem_data_ok = 0; mem_rdata = $urandom; #1;
            tests++;
            if ({inst_valid, inst_rdata, data_data_ok, data_rdata} !== 66'd0) begin
                fails++;
                $display("FAIL resp_clear: got iv=%b ird=%h dok=%b drd=%h, required all 0",
                         inst_valid, inst_rdata, data_data_ok, data_rdata);
            end
        end
        $display("[TB] txn kind=%0d first=%0d stall=%0d wait=%0d cancel=%0b done", kind, order[0],
                 stall, dwait, cancel_first);
    endtask

    task automatic test_reset();
        resetn = 0;
        clear_inputs();
        inst_req = 1; data_req = 1; data_wr = 1; mem_addr_ok = 1; mem_data_ok = 1;
        for (int i = 0; i < 3; i++) begin
            mem_rdata = $urandom;
            @(negedge clk); #1;
            tests++;
            if (all_outs !== 138'd0) begin
                fails++;
                $display("FAIL reset_outputs cycle %0d: got %h, required 0", i, all_outs);
            end
        end
        clear_inputs();
        @(negedge clk);
        resetn = 1;
        lg = 1;
        $display("[TB] reset checked");
    endtask

    task automatic test_fetch();
        inst_req = 1; inst_addr = 32'h1c000000; #1;
        tests++;
        if (mem_req !== 1'b0) begin
            fails++; $display("FAIL fetch_req_delay: got mem_req=%b, required 0", mem_req);
        end
        @(negedge clk); #1;
        tests++;
        if ({mem_req, mem_addr, mem_wr} !== {1'b1, 32'h1c000000, 1'b0}) begin
            fails++;
            $display("FAIL fetch_mem_req: got req=%b addr=%h wr=%b, required req=1 addr=1c000000 wr=0",
                     mem_req, mem_addr, mem_wr);
        end
        mem_addr_ok = 1; #1;
        tests++;
        if (inst_addr_ok !== 1'b1) begin
            fails++; $display("FAIL fetch_addr_ok: got %b, required 1", inst_addr_ok);
        end
        @(negedge clk);
        mem_addr_ok = 0; inst_req = 0;
        @(negedge clk);
        mem_data_ok = 1; mem_rdata = 32'h02800000; #1;
        tests++;
        if ({inst_valid, inst_rdata, data_data_ok} !== {1'b1, 32'h02800000, 1'b0}) begin
            fails++;
            $display("FAIL fetch_valid: got iv=%b ird=%h dok=%b, required iv=1 ird=02800000 dok=0",
                     inst_valid, inst_rdata, data_data_ok);
        end
        @(negedge clk);
        mem_data_ok = 0; #1;
        tests++;
        if ({inst_valid, inst_rdata} !== 33'd0) begin
            fails++; $display("FAIL fetch_valid_pulse: got iv=%b ird=%h, required 0", inst_valid, inst_rdata);
        end
        lg = 1;
        $display("[TB] fetch 1c000000 checked");
    endtask

    task automatic test_priority();
        do_txn(3, 32'h1c000000, 32'h1c000100, 32'h0, 4'h0, 0, 1, 0);
        do_txn(1, 32'h0, 32'h1c000200, 32'h0, 4'hf, 0, 0, 0);
        do_txn(3, 32'h1c000004, 32'h1c000300, 32'h0, 4'h0, 0, 1, 0);
        do_txn(4, 32'h1c000008, 32'h1c000400, 32'h12345678, 4'b1100, 1, 0, 0);
    endtask

    task automatic test_store();
        do_txn(2, 32'h0, 32'h1c000500, 32'hdeadbeef, 4'b0011, 0, 1, 0);
        do_txn(2, 32'h0, 32'h1c000504, 32'hdeadbeef, 4'b0011, 0, 1, 1);
    endtask

    task automatic test_cancel();
        do_txn(0, 32'h1c000010, 32'h0, 32'h0, 4'h0, 0, 1, 1);
        do_txn(0, 32'h1c000014, 32'h0, 32'h0, 4'h0, 0, 1, 0);
        do_txn(1, 32'h0, 32'h1c000600, 32'h0, 4'hf, 0, 2, 1);
        // Cancel in IDLE masks the request for that cycle only.
        inst_req = 1; inst_addr = 32'h1c000018; inst_cancel = 1;
        @(negedge clk); #1;
        tests++;
        if (mem_req !== 1'b0) begin
            fails++; $display("FAIL idle_cancel_mask: got mem_req=%b, required 0", mem_req);
        end
        inst_req = 0; inst_cancel = 0;
        @(negedge clk); #1;
        $display("[TB] idle cancel mask checked");
    endtask

    task automatic test_reset_mid();
        inst_req = 1; inst_addr = 32'h1c000020;
        @(negedge clk);
        mem_addr_ok = 1;
        @(negedge clk);
        mem_addr_ok = 0; inst_req = 0;
        resetn = 0; #1;
        tests++;
        if (all_outs !== 138'd0) begin
            fails++; $display("FAIL reset_mid_outputs: got %h, required 0", all_outs);
        end
        @(negedge clk);
        resetn = 1;
        @(negedge clk);
        mem_data_ok = 1; mem_rdata = 32'hcafef00d; #1;
        tests++;
        if (all_outs !== 138'd0) begin
            fails++; $display("FAIL stale_data_ok: got %h, required 0", all_outs);
        end
        @(negedge clk);
        mem_data_ok = 0; #1;
        tests++;
        if (mem_req !== 1'b0) begin
            fails++; $display("FAIL reset_mid_idle: got mem_req=%b, required 0", mem_req);
        end
        lg = 1;
        $display("[TB] reset mid-transaction checked");
        do_txn(0, 32'h1c000024, 32'h0, 32'h0, 4'h0, 0, 0, 0);
    endtask

    task automatic test_addr_stall();
        do_txn(0, 32'h1c000030, 32'h0, 32'h0, 4'h0, 5, 0, 0);
        do_txn(2, 32'h0, 32'h1c000700, 32'h55aa33cc, 4'b0101, 5, 1, 0);
    endtask

    task automatic test_idle_ignores();
        mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h13579bdf;
        @(negedge clk); #1;
        tests++;
        if (all_outs !== 138'd0) begin
            fails++; $display("FAIL idle_ignores: got %h, required 0", all_outs);
        end
        mem_addr_ok = 0; mem_data_ok = 0;
        @(negedge clk);
        $display("[TB] idle handshakes ignored checked");
        do_txn(3, 32'h1c000040, 32'h1c000800, 32'h0, 4'h3, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_txn($urandom_range(0, 4), {$urandom} & 32'hfffffffc, {$urandom} & 32'hfffffffc,
                   $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                   $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        resetn = 0;
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_cancel();
        test_reset_mid();
        test_addr_stall();
        test_idle_ignores();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
